// File: rtl/gate_probe_pkg.sv
// Shared definitions for the gate probe: gate codes, stimulus vector ROM,
// signature table and FSM state encoding.
package gate_probe_pkg;

    localparam logic [7:0] GATE_AND  = 8'd0;
    localparam logic [7:0] GATE_OR   = 8'd1;
    localparam logic [7:0] GATE_NAND = 8'd2;
    localparam logic [7:0] GATE_NOR  = 8'd4;
    localparam logic [7:0] GATE_XOR  = 8'd8;
    localparam logic [7:0] GATE_XNOR = 8'd16;
    localparam logic [7:0] GATE_SR   = 8'd32;
    localparam logic [7:0] GATE_T    = 8'd64;
    localparam logic [7:0] GATE_D    = 8'd128;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_DECODE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int         NUM_STEPS = 9;
    localparam logic [3:0] LAST_STEP = 4'd8;
    localparam int         NUM_SIGS  = 10;

    typedef struct packed {
        logic       in1;
        logic       in2;
        logic       sample;
        logic [2:0] bit_idx;
    } vec_t;

    typedef struct packed {
        logic [5:0] pattern;
        logic [5:0] mask;
        logic [7:0] code;
        logic       t_phase;
    } sig_entry_t;

    // Signature bits are packed {b0,b1,b2,b3,b4,b5}, so b0 sits in bit 5.
    localparam vec_t VEC_ROM [NUM_STEPS] = '{
        '{1'b1, 1'b0, 1'b0, 3'd0},
        '{1'b0, 1'b0, 1'b0, 3'd0},
        '{1'b0, 1'b1, 1'b1, 3'd0},
        '{1'b0, 1'b0, 1'b1, 3'd1},
        '{1'b1, 1'b0, 1'b1, 3'd2},
        '{1'b1, 1'b1, 1'b1, 3'd3},
        '{1'b1, 1'b0, 1'b1, 3'd4},
        '{1'b0, 1'b0, 1'b0, 3'd0},
        '{1'b0, 1'b1, 1'b1, 3'd5}
    };

    // SR masks b3: the latch output is undefined with both inputs high.
    localparam sig_entry_t SIG_TABLE [NUM_SIGS] = '{
        '{6'b000100, 6'b111111, GATE_AND,  1'b0},
        '{6'b101111, 6'b111111, GATE_OR,   1'b0},
        '{6'b111011, 6'b111111, GATE_NAND, 1'b0},
        '{6'b010000, 6'b111111, GATE_NOR,  1'b0},
        '{6'b101011, 6'b111111, GATE_XOR,  1'b0},
        '{6'b010100, 6'b111111, GATE_XNOR, 1'b0},
        '{6'b001010, 6'b111011, GATE_SR,   1'b0},
        '{6'b000111, 6'b111111, GATE_T,    1'b0},
        '{6'b111000, 6'b111111, GATE_T,    1'b1},
        '{6'b000110, 6'b111111, GATE_D,    1'b0}
    };

endpackage

// File: rtl/gate_signature_decoder.sv
// Combinational lookup from a 6-bit probe signature to a gate code, with
// per-entry don't-care masks.
module gate_signature_decoder
    import gate_probe_pkg::*;
(
    input  logic [5:0] signature,
    output logic       gate_valid,
    output logic [7:0] identified_gate,
    output logic       t_phase
);

    always_comb begin
        gate_valid      = 1'b0;
        identified_gate = 8'd0;
        t_phase         = 1'b0;
        for (int i = NUM_SIGS - 1; i >= 0; i--) begin
            if ((signature & SIG_TABLE[i].mask) == SIG_TABLE[i].pattern) begin
                gate_valid      = 1'b1;
                identified_gate = SIG_TABLE[i].code;
                t_phase         = SIG_TABLE[i].t_phase;
            end
        end
    end

endmodule

// File: rtl/gate_probe_identifier.sv
// Drives a fixed 9-step stimulus onto the gate inputs and decodes the sampled
// output into a gate code. Define GATE_PROBE_SYNC_EN to synchronise gate_out.
module gate_probe_identifier
    import gate_probe_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    output logic       probe_in1,
    output logic       probe_in2,
    input  logic       gate_out,
    output logic       busy,
    output logic       done,
    output logic       gate_valid,
    output logic [7:0] identified_gate,
    output logic       t_phase
);

    localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES > 255) begin : g_settle_too_large
        $error("SETTLE_CYCLES must not exceed 255");
    end

    logic [1:0] state;
    logic [3:0] step;
    logic [3:0] next_step;
    logic [7:0] cnt;
    logic [5:0] signature;
    logic       sample_bit;
    vec_t       cur_vec;
    vec_t       nxt_vec;
    logic       dec_valid;
    logic [7:0] dec_gate;
    logic       dec_t_phase;

`ifdef GATE_PROBE_SYNC_EN
    if (SETTLE_CYCLES < 3) begin : g_settle_too_small
        $error("SETTLE_CYCLES must be at least 3 with the gate_out synchroniser");
    end

    logic gate_sync_p0;
    logic gate_sync_p1;

    // sync stage p0 -> p1
    always_ff @(posedge clk) begin
        gate_sync_p0 <= gate_out;
        gate_sync_p1 <= gate_sync_p0;
    end

    assign sample_bit = gate_sync_p1;
`else
    assign sample_bit = gate_out;
`endif

    always_comb begin
        next_step = step + 4'd1;
        cur_vec   = VEC_ROM[step];
        nxt_vec   = (step == LAST_STEP) ? VEC_ROM[0] : VEC_ROM[next_step];
    end

    gate_signature_decoder u_decoder (
        .signature       (signature),
        .gate_valid      (dec_valid),
        .identified_gate (dec_gate),
        .t_phase         (dec_t_phase)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= ST_IDLE;
            step            <= 4'd0;
            cnt             <= 8'd0;
            signature       <= 6'd0;
            probe_in1       <= 1'b0;
            probe_in2       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            gate_valid      <= 1'b0;
            identified_gate <= 8'd0;
            t_phase         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_DRIVE;
                        step      <= 4'd0;
                        cnt       <= 8'd0;
                        signature <= 6'd0;
                        probe_in1 <= VEC_ROM[0].in1;
                        probe_in2 <= VEC_ROM[0].in2;
                        busy      <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt == LAST_CNT) begin
                        // The last settle cycle of a step captures its sample.
                        if (cur_vec.sample) begin
                            signature[3'd5 - cur_vec.bit_idx] <= sample_bit;
                        end
                        cnt <= 8'd0;
                        if (step == LAST_STEP) begin
                            state     <= ST_DECODE;
                            probe_in1 <= 1'b0;
                            probe_in2 <= 1'b0;
                        end else begin
                            step      <= next_step;
                            probe_in1 <= nxt_vec.in1;
                            probe_in2 <= nxt_vec.in2;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_DECODE: begin
                    state           <= ST_DONE;
                    done            <= 1'b1;
                    busy            <= 1'b0;
                    gate_valid      <= dec_valid;
                    identified_gate <= dec_gate;
                    t_phase         <= dec_t_phase;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
